param_data_memory: RTL and testbench
====================================

Name: param_data_memory

Overview:
- Parametrised single-port data memory for the microprocessor datapath. It is the next generation of the fixed 8-bit-address / 8-bit-data memory.
- Adds generic width and depth, per-lane write enables, a valid/ready request handshake, and a registered read response.
- Adds a self-clearing sequence after reset that zeroes every word.
- Sits between the CPU load/store stage and storage.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of LANE_W.
- LANE_W, 8, bits per write-enable lane.
- ADDR_W, 8, address width.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- write  input  1  1 = write, 0 = read; qualified by req_valid.
- address  input  ADDR_W  word address.
- lane_en  input  DATA_W/LANE_W  per-lane write enable; ignored on reads.
- data_inputs  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse: read data valid.
- data_outputs  output  DATA_W  read data; holds its value between responses.
- err  output  1  one-cycle pulse: accepted request was out of range.
- busy  output  1  clear sequence in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: req_ready=0, busy=1, rsp_valid=0, data_outputs=0, err=0, FSM=CLEAR, clr_addr=0.
- FSM states:
  - CLEAR: while reset is high, hold clr_addr=0. After reset deasserts, write all-zero to mem[clr_addr] each cycle and increment clr_addr. At clr_addr==DEPTH-1 the write completes and the FSM moves to IDLE on that edge. Duration is exactly DEPTH cycles after the first cycle with reset low.
  - IDLE: req_ready=1, busy=0.
- req_ready and busy are registered, derived from the state.
- Accept condition: req_valid && req_ready, sampled at the rising edge.
- Requests presented while req_ready=0 are neither stored nor answered; the requester must hold them.
- Accepted write:
  - For each lane i with lane_en[i]=1, mem[address][i*LANE_W +: LANE_W] <= data_inputs lane i at that edge.
  - Lanes with lane_en[i]=0 are unchanged.
  - lane_en all-zero is a legal no-op with no err.
  - No response; rsp_valid stays 0.
- Accepted read:
  - Accepted at edge N, data_outputs = mem[address] and rsp_valid=1 after edge N+1, for exactly one cycle.
  - Back-to-back reads on consecutive cycles give back-to-back rsp_valid pulses.
- Write followed by read of the same address on the next cycle returns the new data (write-first across cycles). Only one request per cycle, so there is no same-cycle collision.
- Out of range (address >= DEPTH):
  - Write: memory unchanged, err pulses one cycle after acceptance.
  - Read: rsp_valid and err pulse together, data_outputs=0.
  - When DEPTH == 2**ADDR_W, err is never asserted.
- Reset mid-operation:
  - Reset asserted in any state returns to CLEAR with clr_addr=0 and cancels any pending response; rsp_valid=0 on the next cycle.
  - Reset during CLEAR restarts the clear from address 0.
- The lane count must be exact: DATA_W % LANE_W != 0 is a parameter error, caught by an elaboration-time check.
- clr_addr is sized to ADDR_W+1 bits so that DEPTH=2**ADDR_W does not wrap prematurely.

Decomposition:
- Shared package holds:
  - FSM state enum: CLEAR, IDLE.
  - Function computing the lane count, DATA_W/LANE_W.
  - Zero-word constant.
- Sub-module: lane_write_merge, combinational. It merges old word, new data and lane_en into the word to store. It is reused by the clear path with lane_en all-ones and data zero.
- Storage is an inferred array in the top module.

Test Plan:
- Clear sequence: DATA_W=16, ADDR_W=4, DEPTH=12, reset high 3 cycles -> busy=1 and req_ready=0 for exactly 12 cycles after reset falls, then busy=0 and req_ready=1. Reads of addresses 0..11 all return 16'h0000.
- Basic write/read: write 8'h55 to addr 2, then 8'hCC to addr 10, then read 2 and read 10 on consecutive cycles -> rsp_valid pulses on two consecutive cycles with 8'h55 then 8'hCC, err=0 throughout.
- Lane enables: DATA_W=16, write 16'hABCD lane_en=2'b11 to addr 5, then 16'h1234 lane_en=2'b01 -> read 5 returns 16'hAB34. A write with lane_en=2'b00 leaves it at 16'hAB34.
- Out of range: DEPTH=12, write 16'hFFFF to addr 13 -> err pulse with no change to memory. Read of addr 13 -> rsp_valid=1, err=1, data_outputs=0. Read of addr 11 -> prior contents, err=0.
- Handshake stall: assert req_valid with a read of addr 3 during CLEAR -> no rsp_valid. The request is held until req_ready=1, then accepted once and exactly one response is returned.
- Reset mid-clear and mid-read: reset asserted at clr_addr=6 -> clear restarts and busy lasts the full DEPTH cycles again. Reset asserted the cycle after a read is accepted -> rsp_valid stays 0.

Source files
------------

// File: rtl/param_data_memory_pkg.sv
// Shared types and helpers for the parametrised data memory.
package param_data_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  function automatic int lane_count(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/param_data_memory_lane_write_merge.sv
// Combinational merge of old word and new data under per-lane enables.
module lane_write_merge
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANE_W = 8,
  parameter int LANES  = lane_count(DATA_W, LANE_W)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [LANES-1:0]  lane_en,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Single-port data memory: lane-masked writes, two-stage registered reads,
// zero-fill sequence after every reset.
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W/LANE_W-1:0] lane_en,
  input  logic [DATA_W-1:0]        data_inputs,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        data_outputs,
  output logic                     err,
  output logic                     busy
);

  localparam int LANES = lane_count(DATA_W, LANE_W);

  generate
    if (DATA_W % LANE_W != 0) begin : g_lane_chk
      $error("DATA_W must be a multiple of LANE_W");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_depth_chk
      $error("DEPTH must lie in 1..2**ADDR_W");
    end
  endgenerate

  state_t            state;
  logic [ADDR_W:0]   clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              clearing;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_lanes;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] merged;

  // Read pipeline stage between acceptance and the visible response.
  logic              pend_vld;
  logic              pend_err;
  logic [DATA_W-1:0] pend_dat;

  assign accept   = req_valid && req_ready;
  assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
  assign clearing = (state == CLEAR) && !reset;
  assign wr_en    = clearing || (accept && write && in_range);
  assign wr_addr  = clearing ? clr_addr[ADDR_W-1:0] : address;
  assign wr_lanes = clearing ? '1 : lane_en;
  assign wr_data  = clearing ? ZERO_WORD[DATA_W-1:0] : data_inputs;

  lane_write_merge #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .LANES  (LANES)
  ) u_merge (
    .old_word (mem[wr_addr]),
    .new_data (wr_data),
    .lane_en  (wr_lanes),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      req_ready    <= 1'b0;
      busy         <= 1'b1;
      pend_vld     <= 1'b0;
      pend_err     <= 1'b0;
      pend_dat     <= '0;
      rsp_valid    <= 1'b0;
      err          <= 1'b0;
      data_outputs <= '0;
    end else begin
      rsp_valid <= pend_vld;
      err       <= pend_err;
      if (pend_vld) data_outputs <= pend_dat;

      pend_vld <= accept && !write;
      pend_err <= accept && !in_range;
      pend_dat <= in_range ? mem[address] : '0;

      case (state)
        CLEAR: begin
          if (clr_addr == (ADDR_W+1)'(DEPTH-1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: spec-level model checked every cycle plus directed literal checks.
module tb_param_data_memory;

  localparam int DATA_W = 16;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [1:0]        lane_en = '0;
  logic [DATA_W-1:0] data_inputs = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] data_outputs;
  logic              err;
  logic              busy;

  param_data_memory #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .write        (write),
    .address      (address),
    .lane_en      (lane_en),
    .data_inputs  (data_inputs),
    .rsp_valid    (rsp_valid),
    .data_outputs (data_outputs),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: memory contents, clear countdown, one-deep response delay.
  logic [DATA_W-1:0] mmem [DEPTH];
  bit                model_on = 1'b0;
  bit                m_ready, m_busy, m_rsp, m_err;
  logic [DATA_W-1:0] m_dout;
  int                m_clr;
  bit                p_rsp, p_err;
  logic [DATA_W-1:0] p_dat;

  always @(posedge clk) begin : model
    bit acc;
    bit oor;
    if (reset) begin
      model_on = 1'b1;
      m_ready = 0; m_busy = 1; m_rsp = 0; m_err = 0; m_dout = '0;
      m_clr = 0; p_rsp = 0; p_err = 0; p_dat = '0;
    end else if (model_on) begin
      acc = m_ready && req_valid;
      m_rsp = p_rsp;
      m_err = p_err;
      if (p_rsp) m_dout = p_dat;
      p_rsp = 0;
      p_err = 0;
      if (m_busy) begin
        m_clr++;
        if (m_clr == DEPTH) begin
          m_busy = 0;
          m_ready = 1;
          foreach (mmem[i]) mmem[i] = '0;
        end
      end else if (acc) begin
        oor = int'(address) >= DEPTH;
        p_err = oor;
        if (write) begin
          if (!oor)
            for (int i = 0; i < 2; i++)
              if (lane_en[i]) mmem[address][i*8 +: 8] = data_inputs[i*8 +: 8];
        end else begin
          p_rsp = 1;
          p_dat = oor ? '0 : mmem[address];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cmp_ready", 32'(req_ready), 32'(m_ready));
      check("cmp_busy", 32'(busy), 32'(m_busy));
      check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      check("cmp_err", 32'(err), 32'(m_err));
      check("cmp_data", 32'(data_outputs), 32'(m_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [1:0] le,
                       input logic [DATA_W-1:0] d);
    req_valid = 1'b1; write = w; address = a; lane_en = le; data_inputs = d;
    tick();
    req_valid = 1'b0; write = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp_d, input bit exp_err);
    issue(1'b0, a, 2'b00, '0);
    tick();
    check({name, "_rsp"}, 32'(rsp_valid), 32'd1);
    check({name, "_data"}, 32'(data_outputs), 32'(exp_d));
    check({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (busy === 1'b0) break;
    end
  endtask

  initial begin
    int n, accepted, rsp_cnt, busy_cnt;
    bit was_ready;
    logic [DATA_W-1:0] got;

    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp", 32'(rsp_valid), 32'd0);
    check("reset_data", 32'(data_outputs), 32'd0);
    reset = 1'b0;
    wait_clear(n);
    check("clear_len", 32'(n), 32'd12);
    check("clear_ready", 32'(req_ready), 32'd1);
    for (int a = 0; a < DEPTH; a++) read_chk("clear_zero", ADDR_W'(a), 16'h0000, 1'b0);

    issue(1'b1, 4'd2, 2'b11, 16'h0055);
    issue(1'b1, 4'd10, 2'b11, 16'h00CC);
    req_valid = 1'b1; write = 1'b0; address = 4'd2;
    tick();
    address = 4'd10;
    tick();
    req_valid = 1'b0;
    check("b2b_rsp0", 32'(rsp_valid), 32'd1);
    check("b2b_data0", 32'(data_outputs), 32'h0055);
    tick();
    check("b2b_rsp1", 32'(rsp_valid), 32'd1);
    check("b2b_data1", 32'(data_outputs), 32'h00CC);
    check("b2b_err", 32'(err), 32'd0);
    tick();
    check("b2b_done", 32'(rsp_valid), 32'd0);
    check("b2b_hold", 32'(data_outputs), 32'h00CC);

    issue(1'b1, 4'd5, 2'b11, 16'hABCD);
    issue(1'b1, 4'd5, 2'b01, 16'h1234);
    read_chk("lane_merge", 4'd5, 16'hAB34, 1'b0);
    issue(1'b1, 4'd5, 2'b00, 16'h0000);
    read_chk("lane_none", 4'd5, 16'hAB34, 1'b0);

    issue(1'b1, 4'd11, 2'b11, 16'h1111);
    issue(1'b1, 4'd13, 2'b11, 16'hFFFF);
    tick();
    check("oor_wr_err", 32'(err), 32'd1);
    check("oor_wr_rsp", 32'(rsp_valid), 32'd0);
    read_chk("oor_rd", 4'd13, 16'h0000, 1'b1);
    read_chk("in_rd11", 4'd11, 16'h1111, 1'b0);

    issue(1'b0, 4'd5, 2'b00, '0);
    reset = 1'b1;
    tick();
    check("rst_mid_read_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;

    req_valid = 1'b1; write = 1'b0; address = 4'd3;
    accepted = 0; rsp_cnt = 0; busy_cnt = 0; got = 'x;
    for (int i = 0; i < 24; i++) begin
      was_ready = req_ready;
      if (busy) busy_cnt++;
      tick();
      if (was_ready && req_valid) begin
        req_valid = 1'b0;
        accepted++;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        got = data_outputs;
      end
    end
    check("stall_busy_len", 32'(busy_cnt), 32'd12);
    check("stall_accepts", 32'(accepted), 32'd1);
    check("stall_rsps", 32'(rsp_cnt), 32'd1);
    check("stall_data", 32'(got), 32'h0000);

    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("midclr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear(n);
    check("midclr_len", 32'(n), 32'd12);
    read_chk("after_clear", 4'd5, 16'h0000, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
